// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the completion / common-data-bus path.
// The writeback packet travels from the FUs through the CDB arbiter to the ROB, PRF and RS.
package cdb_arbiter_pkg;

    localparam int CDB_N_SRC = 3;
    localparam int CDB_SRC_W = 2;

    typedef enum logic [CDB_SRC_W-1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_BRU = 2'd2
    } cdb_src_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_tag;
        logic [6:0]  prd;
        logic        rd_used;
        logic [31:0] data;
    } wb_pkt_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback packets, one per completion source.
// Pushes while full and pops while empty are ignored; clr empties it in one cycle.
module wb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  wb_pkt_t       din,
    output wb_pkt_t       dout,
    output logic [CW-1:0] count
);

    wb_pkt_t       mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push & (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop & (count_r != CW'(0));
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clr) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(1'b0);
            rd_ptr_r <= AW'(1'b0);
            count_r  <= CW'(1'b0);
        end else if (clr) begin
            wr_ptr_r <= AW'(1'b0);
            rd_ptr_r <= AW'(1'b0);
            count_r  <= CW'(1'b0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter merging the ALU/LSU/BRU completion FIFOs onto one registered CDB.
// Ready depends on FIFO occupancy only, so there is no valid-to-ready combinational path.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC  = CDB_N_SRC,
    parameter int QDEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N_SRC-1:0]     src_valid,
    input  wb_pkt_t [N_SRC-1:0]  src_pkt,
    output logic [N_SRC-1:0]     src_ready,
    output wb_pkt_t              cdb_pkt,
    output logic [CDB_SRC_W-1:0] cdb_src
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [CW-1:0]        count_s [N_SRC];
    wb_pkt_t              head_s  [N_SRC];
    logic [N_SRC-1:0]     nonempty_s;
    logic [N_SRC-1:0]     push_s;
    logic [N_SRC-1:0]     pop_s;
    logic                 grant_vld_s;
    logic [CDB_SRC_W-1:0] grant_idx_s;
    wb_pkt_t              grant_pkt_s;
    logic [CDB_SRC_W-1:0] rr_ptr_r;

    function automatic logic [CDB_SRC_W-1:0] wrap_idx(input logic [CDB_SRC_W-1:0] base,
                                                      input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_SRC) begin
            sum = sum - N_SRC;
        end else begin
            sum = sum;
        end
        return CDB_SRC_W'(sum);
    endfunction

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign src_ready[gi]  = (count_s[gi] != CW'(QDEPTH));
        assign nonempty_s[gi] = (count_s[gi] != CW'(0));

        wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clr   (flush),
            .push  (push_s[gi]),
            .pop   (pop_s[gi]),
            .din   (src_pkt[gi]),
            .dout  (head_s[gi]),
            .count (count_s[gi])
        );
    end

    assign push_s = src_valid & src_ready & {N_SRC{~flush}};

    // Rotate-then-find-first: first non-empty FIFO at or after rr_ptr_r.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = CDB_SRC_W'(1'b0);
        for (int k = 0; k < N_SRC; k++) begin
            if (!grant_vld_s && nonempty_s[wrap_idx(rr_ptr_r, k)]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = wrap_idx(rr_ptr_r, k);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Pop the granted head and force its valid bit for the broadcast.
    always_comb begin
        pop_s       = {N_SRC{1'b0}};
        grant_pkt_s = head_s[grant_idx_s];
        grant_pkt_s.valid = 1'b1;
        if (grant_vld_s && !flush) begin
            pop_s[grant_idx_s] = 1'b1;
        end else begin
            pop_s = {N_SRC{1'b0}};
        end
    end

    // CDB output register and round-robin pointer; idle cycles keep the payload fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_pkt  <= wb_pkt_t'({$bits(wb_pkt_t){1'b0}});
            cdb_src  <= CDB_SRC_W'(1'b0);
            rr_ptr_r <= CDB_SRC_W'(1'b0);
        end else if (flush) begin
            cdb_pkt.valid <= 1'b0;
            rr_ptr_r      <= CDB_SRC_W'(1'b0);
        end else if (grant_vld_s) begin
            cdb_pkt  <= grant_pkt_s;
            cdb_src  <= grant_idx_s;
            rr_ptr_r <= wrap_idx(grant_idx_s, 1);
        end else begin
            cdb_pkt.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, backpressure, flush and async reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [2:0]          src_valid;
    wb_pkt_t [2:0]       src_pkt;
    logic [2:0]          src_ready;
    wb_pkt_t             cdb_pkt;
    logic [1:0]          cdb_src;

    int n_cmp = 0;
    int n_mis = 0;

    cdb_arbiter #(.N_SRC(3), .QDEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_pkt   (src_pkt),
        .src_ready (src_ready),
        .cdb_pkt   (cdb_pkt),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_pkt_t mk(input logic [5:0] tag, input logic [6:0] prd,
                                   input logic [31:0] data);
        wb_pkt_t p;
        p = '0;
        p.rob_tag = tag;
        p.prd     = prd;
        p.rd_used = 1'b1;
        p.data    = data;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic exp_v, input logic [1:0] exp_src,
                           input logic [31:0] exp_data);
        chk({tag, "_valid"}, 64'(cdb_pkt.valid), 64'(exp_v));
        if (exp_v) begin
            chk({tag, "_src"}, 64'(cdb_src), 64'(exp_src));
            chk({tag, "_data"}, 64'(cdb_pkt.data), 64'(exp_data));
        end
    endtask

    task automatic do_flush();
        flush     = 1'b1;
        src_valid = 3'b000;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int  aidx;
        int  lidx;
        logic acc_a;
        logic acc_l;
        logic        exp_rdyl [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_v4   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0]  exp_s4   [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        logic [31:0] exp_d4   [9] = '{32'h0, 32'hA000, 32'hB000, 32'hA001, 32'hB001,
                                      32'hA002, 32'hB002, 32'hA003, 32'hB003};

        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = 3'b000;
        src_pkt   = '0;
        #2;
        chk("rst_pkt", 64'(cdb_pkt), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'h7);
        #10 rst = 1'b0;

        // Single ALU packet: accepted at edge 1, on the CDB after edge 2, gone after edge 3.
        src_valid  = 3'b001;
        src_pkt[0] = mk(6'd5, 7'd17, 32'h1234);
        tick();
        src_valid = 3'b000;
        chk("t1_nobypass", 64'(cdb_pkt.valid), 64'd0);
        tick();
        chk_cdb("t1_grant", 1'b1, 2'd0, 32'h1234);
        chk("t1_tag", 64'(cdb_pkt.rob_tag), 64'd5);
        chk("t1_prd", 64'(cdb_pkt.prd), 64'd17);
        tick();
        chk("t1_idle", 64'(cdb_pkt.valid), 64'd0);
        do_flush();

        // Three sources at once from rr_ptr 0: ALU, LSU, BRU, then idle.
        src_valid  = 3'b111;
        src_pkt[0] = mk(6'd1, 7'd1, 32'h11);
        src_pkt[1] = mk(6'd2, 7'd2, 32'h22);
        src_pkt[2] = mk(6'd3, 7'd3, 32'h33);
        tick();
        src_valid = 3'b000;
        tick(); chk_cdb("t2_g0", 1'b1, 2'd0, 32'h11);
        tick(); chk_cdb("t2_g1", 1'b1, 2'd1, 32'h22);
        tick(); chk_cdb("t2_g2", 1'b1, 2'd2, 32'h33);
        tick(); chk_cdb("t2_idle", 1'b0, 2'd0, 32'h0);
        // rr_ptr wrapped to 0: ALU must beat LSU.
        src_valid  = 3'b011;
        src_pkt[0] = mk(6'd4, 7'd4, 32'h44);
        src_pkt[1] = mk(6'd5, 7'd5, 32'h55);
        tick();
        src_valid = 3'b000;
        tick(); chk_cdb("t2_wrap0", 1'b1, 2'd0, 32'h44);
        tick(); chk_cdb("t2_wrap1", 1'b1, 2'd1, 32'h55);
        tick(); chk_cdb("t2_wrapidle", 1'b0, 2'd0, 32'h0);
        do_flush();

        // ALU and BRU continuously valid: grants alternate 0,2,0,2.
        src_valid  = 3'b101;
        src_pkt[0] = mk(6'd6, 7'd6, 32'h66);
        src_pkt[2] = mk(6'd7, 7'd7, 32'h77);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_valid", 64'(cdb_pkt.valid), 64'd1);
            chk("t3_src", 64'(cdb_src), (i % 2 == 0) ? 64'd0 : 64'd2);
        end
        do_flush();
        chk("flush_ready", 64'(src_ready), 64'h7);

        // Backpressure: ALU floods while LSU sends four packets through a depth-2 FIFO.
        aidx = 0;
        lidx = 0;
        for (int e = 0; e < 9; e++) begin
            src_valid[0] = 1'b1;
            src_pkt[0]   = mk(6'd8, 7'd8, 32'hA000 + 32'(aidx));
            src_valid[1] = (lidx < 4);
            src_pkt[1]   = mk(6'd9, 7'd9, 32'hB000 + 32'(lidx));
            src_valid[2] = 1'b0;
            acc_a = src_valid[0] & src_ready[0];
            acc_l = src_valid[1] & src_ready[1];
            tick();
            if (acc_a) aidx++;
            if (acc_l) lidx++;
            chk("t4_ready_lsu", 64'(src_ready[1]), 64'(exp_rdyl[e]));
            chk_cdb("t4_cdb", exp_v4[e], exp_s4[e], exp_d4[e]);
        end
        chk("t4_lsu_sent", 64'(lidx), 64'd4);
        do_flush();

        // Flush with full FIFOs and new inputs present: nothing survives.
        src_valid  = 3'b111;
        src_pkt[0] = mk(6'd10, 7'd10, 32'h1);
        src_pkt[1] = mk(6'd11, 7'd11, 32'h2);
        src_pkt[2] = mk(6'd12, 7'd12, 32'h3);
        tick(); tick(); tick();
        src_pkt[0] = mk(6'd13, 7'd13, 32'hDEAD);
        src_pkt[1] = mk(6'd13, 7'd13, 32'hDEAD);
        src_pkt[2] = mk(6'd13, 7'd13, 32'hDEAD);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        src_valid = 3'b000;
        chk("t5_valid", 64'(cdb_pkt.valid), 64'd0);
        chk("t5_ready", 64'(src_ready), 64'h7);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_drained", 64'(cdb_pkt.valid), 64'd0);
        end

        // Async reset mid-burst after an ALU grant has moved rr_ptr to 1.
        src_valid  = 3'b111;
        src_pkt[0] = mk(6'd14, 7'd14, 32'h61);
        src_pkt[1] = mk(6'd15, 7'd15, 32'h62);
        src_pkt[2] = mk(6'd16, 7'd16, 32'h63);
        tick();
        tick();
        chk_cdb("t6_pre", 1'b1, 2'd0, 32'h61);
        #2;
        rst       = 1'b1;
        src_valid = 3'b000;
        #1;
        chk("t6_valid", 64'(cdb_pkt.valid), 64'd0);
        chk("t6_ready", 64'(src_ready), 64'h7);
        chk("t6_src", 64'(cdb_src), 64'd0);
        rst = 1'b0;
        src_valid  = 3'b011;
        src_pkt[0] = mk(6'd17, 7'd17, 32'h71);
        src_pkt[1] = mk(6'd18, 7'd18, 32'h72);
        tick();
        src_valid = 3'b000;
        tick(); chk_cdb("t6_g0", 1'b1, 2'd0, 32'h71);
        tick(); chk_cdb("t6_g1", 1'b1, 2'd1, 32'h72);
        tick(); chk_cdb("t6_idle", 1'b0, 2'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the three functional-unit completion streams (ALU, LSU, BRU) onto a single shared common data bus (CDB) that feeds the ROB, PRF write port and RS wakeup. Each source gets a small FIFO so an FU can complete without stalling on CDB conflicts. Arbitration is round-robin, and the CDB output is registered. The block sits between the FU stage and the writeback/wakeup consumers and is cleared by pipeline flush.

## Interface
Parameters:
- N_SRC, 3: number of completion sources; index 0 = ALU, 1 = LSU, 2 = BRU.
- QDEPTH, 2: per-source FIFO depth in entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered and in-flight completions.
- src_valid  in  N_SRC  per-source completion request.
- src_pkt  in  N_SRC x wb_pkt_t  per-source completion packet; the packet's own `valid` field is ignored and `src_valid` is authoritative.
- src_ready  out  N_SRC  per-source FIFO can accept a packet this cycle.
- cdb_pkt  out  wb_pkt_t  registered CDB broadcast; `cdb_pkt.valid` qualifies the packet.
- cdb_src  out  2  index of the source granted for the current `cdb_pkt`.

## Operation
- Enqueue: on a clock edge where `src_valid[i] & src_ready[i]` and `flush` is 0, `src_pkt[i]` is written to FIFO i.
- `src_ready[i] = (count[i] != QDEPTH)`. It depends only on registered count, with no combinational path from any valid signal or from a dequeue.
  - A full FIFO therefore deasserts ready even in a cycle where it dequeues.
- Candidate set: every FIFO with `count != 0`.
- Round-robin pointer `rr_ptr` (0..N_SRC-1) marks the highest-priority source. The winner is the first non-empty FIFO at or after `rr_ptr`, searching in increasing index order with wrap-around.
- On a grant to source g:
  - FIFO g pops its head.
  - `cdb_pkt` is loaded with the head, with `valid` forced to 1.
  - `cdb_src` is set to g.
  - `rr_ptr` becomes `(g+1) mod N_SRC`; when g = N_SRC-1, it wraps to 0.
- No candidate: `cdb_pkt.valid` is 0, the other `cdb_pkt` fields hold their previous values, and `rr_ptr` is unchanged.
- One grant per cycle. The CDB is never back-pressured: consumers always accept.
- Packets with `rd_used = 0` (stores, branches without rd) still use the CDB because the ROB needs their completion. Arbitration ignores `rd_used`.
- Simultaneous enqueue and dequeue on the same FIFO: count is unchanged and order is preserved (FIFO order within a source).
- Flush, synchronous, has priority over everything else. At the edge:
  - all FIFO counts and pointers are cleared;
  - `cdb_pkt.valid` becomes 0;
  - `rr_ptr` becomes 0;
  - that cycle's inputs are dropped.
- Reset values: FIFO counts and pointers 0, `rr_ptr` 0, `cdb_pkt` all-zero (valid 0), `cdb_src` 0. `src_ready` is all 1 after reset because counts are 0.
- Reset asserted mid-operation discards all buffered packets immediately (asynchronous).

## Timing
- Minimum latency is 2 edges. A packet accepted at edge t is in its FIFO during cycle t+1 and is granted at edge t+1. `cdb_pkt.valid` is visible in cycle t+2. There is no input-to-CDB bypass.
- Throughput is 1 packet per cycle aggregate. A single source with continuous `src_valid` and no contention sustains 1 per cycle with QDEPTH ≥ 2.
- Worst-case wait for a non-empty FIFO head is N_SRC-1 grants (round-robin fairness).
- All outputs are registers or functions of registered counts only.

## Structure
- Shared package additions:
  - `CDB_N_SRC` = 3.
  - `cdb_src_t` enum: SRC_ALU = 0, SRC_LSU = 1, SRC_BRU = 2.
  - `wb_pkt_t` is reused unchanged.
- Sub-module `wb_fifo`: a parameterised synchronous FIFO of `wb_pkt_t`.
  - Ports: clk, rst, clr, push, pop, din, dout, count.
  - Instantiated N_SRC times.
- The arbitration logic (priority rotate plus find-first) and the output register live in `cdb_arbiter`.

## Test plan
- Reset then single ALU packet: drive `src_valid[0]` with rob_tag 5, prd 17, data 0x1234 at edge 1. Require `cdb_pkt.valid` = 1, rob_tag 5, prd 17, data 0x1234 and `cdb_src` = 0 after edge 2, and `cdb_pkt.valid` = 0 after edge 3.
- All three sources present one packet at the same edge, starting from `rr_ptr` = 0: require the CDB to carry ALU, LSU, BRU on three consecutive cycles, then idle, with `rr_ptr` back at 0.
- Fairness and wrap: hold ALU and BRU continuously valid. Require the grants to alternate 0, 2, 0, 2, …, and LSU is never granted while it is empty.
- Backpressure: hold `src_valid[1]` for 4 cycles while ALU floods. Require `src_ready[1]` = 0 exactly while count = 2, with no packet lost or duplicated and LSU packets emerging in order.
- Flush: fill all FIFOs, then assert `flush` for one cycle with new `src_valid` present. Require `cdb_pkt.valid` = 0 the next cycle, all `src_ready` = 1, and the dropped inputs never appearing.
- Asynchronous reset mid-burst: assert `rst` between edges. Require `cdb_pkt.valid` = 0 and all counts = 0 immediately, and correct operation restarting from `rr_ptr` = 0 after release.
